// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, control-word bit layout, FSM state
// encoding and the control ROM function used by decode_rom.
package decode_pkg;

  localparam int OPND_W_MAX = 16;
  localparam int CTRL_USED  = 19;

  localparam logic [3:0] OPC_SYS  = 4'h0;
  localparam logic [3:0] OPC_MOV  = 4'h1;
  localparam logic [3:0] OPC_LDI  = 4'h2;
  localparam logic [3:0] OPC_MVI  = 4'h3;
  localparam logic [3:0] OPC_LD0  = 4'h4;
  localparam logic [3:0] OPC_LD1  = 4'h5;
  localparam logic [3:0] OPC_ST0  = 4'h6;
  localparam logic [3:0] OPC_ST1  = 4'h7;
  localparam logic [3:0] OPC_JMP  = 4'h8;
  localparam logic [3:0] OPC_JZ   = 4'h9;
  localparam logic [3:0] OPC_JC   = 4'hA;
  localparam logic [3:0] OPC_ILL0 = 4'hB;
  localparam logic [3:0] OPC_ADD  = 4'hC;
  localparam logic [3:0] OPC_SUB  = 4'hD;
  localparam logic [3:0] OPC_AND  = 4'hE;
  localparam logic [3:0] OPC_ILL1 = 4'hF;

  localparam logic [OPND_W_MAX-1:0] SYS_NOP  = 16'd0;
  localparam logic [OPND_W_MAX-1:0] SYS_HALT = 16'd1;
  localparam logic [OPND_W_MAX-1:0] SYS_OUT  = 16'd2;

  // Control-word bit positions; bits CTRL_USED and up are reserved (zero).
  localparam int CB_ALU_LSB  = 0;   // 3 bits
  localparam int CB_REG_WE   = 3;
  localparam int CB_MEM_RD   = 4;
  localparam int CB_MEM_WR   = 5;
  localparam int CB_PC_LD    = 6;
  localparam int CB_OUT_LD   = 7;
  localparam int CB_HALT     = 8;
  localparam int CB_TRAP     = 9;
  localparam int CB_SRC_LSB  = 10;  // 2 bits
  localparam int CB_ADDR_SEL = 12;
  localparam int CB_COND_Z   = 13;
  localparam int CB_COND_C   = 14;
  localparam int CB_FLAG_WE  = 15;
  localparam int CB_IMM_EN   = 16;
  localparam int CB_MAR_LD   = 17;
  localparam int CB_MDR_LD   = 18;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;

  localparam logic [1:0] SRC_REG = 2'd0;
  localparam logic [1:0] SRC_IMM = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef logic [CTRL_USED-1:0] ctrl_t;

  function automatic logic is_system(input logic [3:0] opc);
    return opc == OPC_SYS;
  endfunction

  function automatic logic is_two_op(input logic [3:0] opc);
    return (opc >= OPC_LD0) && (opc <= OPC_ST1);
  endfunction

  function automatic logic is_illegal(input logic [3:0] opc,
                                      input logic [OPND_W_MAX-1:0] opnd);
    case (opc)
      OPC_SYS:            return opnd > SYS_OUT;
      OPC_ILL0, OPC_ILL1: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t ctrl_rom(input logic [3:0] opc,
                                     input logic [OPND_W_MAX-1:0] opnd,
                                     input logic phase);
    ctrl_t c;
    c = '0;
    case (opc)
      OPC_SYS: begin
        if (opnd == SYS_HALT)     c[CB_HALT]   = 1'b1;
        else if (opnd == SYS_OUT) c[CB_OUT_LD] = 1'b1;
      end
      OPC_MOV: begin
        c[CB_REG_WE]         = 1'b1;
        c[CB_SRC_LSB +: 2]   = SRC_REG;
      end
      OPC_LDI, OPC_MVI: begin
        c[CB_REG_WE]         = 1'b1;
        c[CB_SRC_LSB +: 2]   = SRC_IMM;
        c[CB_IMM_EN]         = 1'b1;
        c[CB_FLAG_WE]        = (opc == OPC_MVI);
      end
      // Memory ops: phase 0 loads the address register, phase 1 moves data.
      OPC_LD0, OPC_LD1: begin
        if (!phase) begin
          c[CB_MAR_LD]       = 1'b1;
          c[CB_ADDR_SEL]     = opc[0];
        end else begin
          c[CB_MEM_RD]       = 1'b1;
          c[CB_REG_WE]       = 1'b1;
          c[CB_SRC_LSB +: 2] = SRC_MEM;
        end
      end
      OPC_ST0, OPC_ST1: begin
        if (!phase) begin
          c[CB_MAR_LD]       = 1'b1;
          c[CB_ADDR_SEL]     = opc[0];
        end else begin
          c[CB_MEM_WR]       = 1'b1;
          c[CB_MDR_LD]       = 1'b1;
        end
      end
      OPC_JMP, OPC_JZ, OPC_JC: begin
        c[CB_PC_LD]          = 1'b1;
        c[CB_IMM_EN]         = 1'b1;
        c[CB_COND_Z]         = (opc == OPC_JZ);
        c[CB_COND_C]         = (opc == OPC_JC);
      end
      OPC_ADD, OPC_SUB, OPC_AND: begin
        c[CB_REG_WE]         = 1'b1;
        c[CB_FLAG_WE]        = 1'b1;
        c[CB_SRC_LSB +: 2]   = SRC_ALU;
        c[CB_ALU_LSB +: 3]   = (opc == OPC_ADD) ? ALU_ADD :
                               (opc == OPC_SUB) ? ALU_SUB : ALU_AND;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_rom.sv
// Combinational decode: control word, one-hot register targets and instruction
// class flags. DECODE_ILLEGAL_TRAP_EN adds the TRAP bit on illegal opcodes.
module decode_rom
  import decode_pkg::*;
#(
  parameter int OPC_W    = 4,
  parameter int REGSEL_W = 2,
  parameter int INSTR_W  = 8,
  parameter int CTRL_W   = 28
) (
  input  logic [INSTR_W-1:0]     instr_i,
  input  logic                   phase_i,
  output logic [CTRL_W-1:0]      ctrl_o,
  output logic [2**REGSEL_W-1:0] tgt1_o,
  output logic [2**REGSEL_W-1:0] tgt2_o,
  output logic                   illegal_o,
  output logic                   two_op_o,
  output logic                   halt_o
);

  localparam int NREG   = 2**REGSEL_W;
  localparam int OPND_W = 2*REGSEL_W;

  logic [OPC_W-1:0]      opc;
  logic [3:0]            opc4;
  logic [REGSEL_W-1:0]   dst;
  logic [REGSEL_W-1:0]   src;
  logic [OPND_W_MAX-1:0] opnd;
  ctrl_t                 ctrl_base;
  logic                  reg_tgt;

  assign opc  = instr_i[INSTR_W-1 -: OPC_W];
  assign opc4 = 4'(opc);
  assign dst  = instr_i[2*REGSEL_W-1:REGSEL_W];
  assign src  = instr_i[REGSEL_W-1:0];
  assign opnd = OPND_W_MAX'(instr_i[OPND_W-1:0]);

  assign ctrl_base = ctrl_rom(opc4, opnd, phase_i);
  assign illegal_o = is_illegal(opc4, opnd);
  assign two_op_o  = is_two_op(opc4);
  assign halt_o    = is_system(opc4) && (opnd == SYS_HALT);

  always_comb begin
    ctrl_o = CTRL_W'(ctrl_base);
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (illegal_o) ctrl_o[CB_TRAP] = 1'b1;
`endif
  end

  // System ops and illegal encodings carry no register targets.
  assign reg_tgt = !illegal_o && !is_system(opc4);
  assign tgt1_o  = reg_tgt ? (NREG'(1) << dst) : '0;
  assign tgt2_o  = reg_tgt ? (NREG'(1) << src) : '0;

endmodule

// File: rtl/decode_stage.sv
// Registered instruction decoder with valid/ready handshake, load/store
// expansion and HALT hold. Define DECODE_ILLEGAL_TRAP_EN to trap on illegal opcodes.
module decode_stage
  import decode_pkg::*;
#(
  parameter int OPC_W    = 4,
  parameter int REGSEL_W = 2,
  parameter int INSTR_W  = 8,
  parameter int CTRL_W   = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [2**REGSEL_W-1:0] out_tgt1,
  output logic [2**REGSEL_W-1:0] out_tgt2,
  output logic                   out_phase,
  output logic                   out_illegal,
  output logic                   halted,
  input  logic                   resume
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                   err_illegal
`endif
);

  localparam int NREG = 2**REGSEL_W;

  if (INSTR_W != OPC_W + 2*REGSEL_W) begin : g_bad_instr_w
    $error("decode_stage: INSTR_W must equal OPC_W + 2*REGSEL_W");
  end
  if (OPC_W != 4) begin : g_bad_opc_w
    $error("decode_stage: opcode map is defined for OPC_W == 4");
  end
  if (CTRL_W < CTRL_USED) begin : g_bad_ctrl_w
    $error("decode_stage: CTRL_W too narrow for the control-bit layout");
  end

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   exp_instr_q, exp_instr_d;

  logic                 out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]    out_ctrl_q, out_ctrl_d;
  logic [NREG-1:0]      out_tgt1_q, out_tgt1_d;
  logic [NREG-1:0]      out_tgt2_q, out_tgt2_d;
  logic                 out_phase_q, out_phase_d;
  logic                 out_illegal_q, out_illegal_d;

  logic [INSTR_W-1:0]   rom_instr;
  logic                 rom_phase;
  logic [CTRL_W-1:0]    rom_ctrl;
  logic [NREG-1:0]      rom_tgt1, rom_tgt2;
  logic                 rom_illegal, rom_two_op, rom_halt;

  logic                 out_free, accept, exp_fire, load_uop;

  // In EXPAND the ROM sees the latched instruction to build phase 1.
  assign rom_phase = (state_q == ST_EXPAND);
  assign rom_instr = rom_phase ? exp_instr_q : in_instr;

  decode_rom #(
    .OPC_W   (OPC_W),
    .REGSEL_W(REGSEL_W),
    .INSTR_W (INSTR_W),
    .CTRL_W  (CTRL_W)
  ) u_rom (
    .instr_i  (rom_instr),
    .phase_i  (rom_phase),
    .ctrl_o   (rom_ctrl),
    .tgt1_o   (rom_tgt1),
    .tgt2_o   (rom_tgt2),
    .illegal_o(rom_illegal),
    .two_op_o (rom_two_op),
    .halt_o   (rom_halt)
  );

  assign out_free = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign exp_fire = (state_q == ST_EXPAND) && out_valid_q && out_ready;
  assign load_uop = accept || exp_fire;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (rom_halt)        state_d = ST_HALTED;
          else if (rom_two_op) state_d = ST_EXPAND;
`ifdef DECODE_ILLEGAL_TRAP_EN
          else if (rom_illegal) state_d = ST_HALTED;
`endif
        end
      end
      ST_EXPAND: if (exp_fire) state_d = ST_IDLE;
      ST_HALTED: if (resume)   state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE) && out_free;
    halted   = (state_q == ST_HALTED);
  end

  always_comb begin
    exp_instr_d   = accept ? in_instr : exp_instr_q;
    out_valid_d   = out_valid_q;
    out_ctrl_d    = out_ctrl_q;
    out_tgt1_d    = out_tgt1_q;
    out_tgt2_d    = out_tgt2_q;
    out_phase_d   = out_phase_q;
    out_illegal_d = out_illegal_q;
    if (load_uop) begin
      out_valid_d   = 1'b1;
      out_ctrl_d    = rom_ctrl;
      out_tgt1_d    = rom_tgt1;
      out_tgt2_d    = rom_tgt2;
      out_phase_d   = rom_phase;
      out_illegal_d = rom_illegal;
    end else if (out_free) begin
      // Slot drained with nothing to replace it: present an all-zero bubble.
      out_valid_d   = 1'b0;
      out_ctrl_d    = '0;
      out_tgt1_d    = '0;
      out_tgt2_d    = '0;
      out_phase_d   = 1'b0;
      out_illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_instr_q   <= '0;
      out_valid_q   <= 1'b0;
      out_ctrl_q    <= '0;
      out_tgt1_q    <= '0;
      out_tgt2_q    <= '0;
      out_phase_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      exp_instr_q   <= exp_instr_d;
      out_valid_q   <= out_valid_d;
      out_ctrl_q    <= out_ctrl_d;
      out_tgt1_q    <= out_tgt1_d;
      out_tgt2_q    <= out_tgt2_d;
      out_phase_q   <= out_phase_d;
      out_illegal_q <= out_illegal_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic err_illegal_q, err_illegal_d;

  // Sticky until reset; resume deliberately leaves it set.
  assign err_illegal_d = err_illegal_q || (accept && rom_illegal);

  always_ff @(posedge clk) begin
    if (rst) err_illegal_q <= 1'b0;
    else     err_illegal_q <= err_illegal_d;
  end

  assign err_illegal = err_illegal_q;
`endif

  assign out_valid   = out_valid_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_tgt1    = out_tgt1_q;
  assign out_tgt2    = out_tgt2_q;
  assign out_phase   = out_phase_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, registered successor to the combinational instruction decoder of the 8-bit CPU model.
- Accepts one instruction per valid/ready handshake and emits a control word plus one-hot register targets through a registered output with backpressure.
- Expands load/store into two micro-ops and holds a HALT state until resumed.
- Sits between instruction fetch and the datapath/register-file control.

Parameters:
- OPC_W, 4, opcode field width, instr[INSTR_W-1 -: OPC_W].
- REGSEL_W, 2, width of each register-select field: dst = instr[2*REGSEL_W-1:REGSEL_W], src = instr[REGSEL_W-1:0].
- INSTR_W, 8, instruction width; must equal OPC_W+2*REGSEL_W (elaboration-time check, $error on mismatch).
- CTRL_W, 28, control-word width; bit positions come from the package.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction valid.
- in_instr  in  INSTR_W  instruction.
- in_ready  out  1  decoder can accept.
- out_valid  out  1  micro-op valid.
- out_ready  in  1  datapath accepts micro-op.
- out_ctrl  out  CTRL_W  control word.
- out_tgt1  out  2**REGSEL_W  one-hot dst register.
- out_tgt2  out  2**REGSEL_W  one-hot src register.
- out_phase  out  1  0 = first/only micro-op, 1 = second micro-op.
- out_illegal  out  1  current micro-op came from an illegal opcode.
- halted  out  1  decoder in HALTED state.
- resume  in  1  leave HALTED.

Behaviour:
- Reset (any state, including mid-expansion):
  - state=IDLE; all outputs 0; any pending second micro-op is discarded.
  - rst has priority over resume and over all handshakes.
- Opcodes (OPC_W=4):
  - 0000 system:
    - operand 0 = NOP (all-zero ctrl).
    - operand 1 = HALT.
    - operand 2 = OUT.
    - operand 3..15 illegal.
  - 0001-0011: MOV/LDI/MVI, single micro-op.
  - 0100-0101: LOAD, two micro-ops.
  - 0110-0111: STORE, two micro-ops.
  - 1000-1010: JMP/JZ/JC, single micro-op.
  - 1011 and 1111: illegal.
  - 1100-1110: ADD/SUB/AND, single micro-op.
- Targets: out_tgt1 = 1<<dst, out_tgt2 = 1<<src for every legal micro-op; 0 for system and illegal.
- Output register:
  - Loads when out_valid==0 or out_ready==1; otherwise all out_* hold stable.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Combinational from state and out_ready; no in_valid dependency.
- Latency and throughput:
  - Instruction accepted at edge N is visible on out_* after edge N (1 cycle).
  - Single-micro-op throughput is 1 per cycle with out_ready held high.
- States:
  - IDLE:
    - Accept single-op instruction: load micro-op, stay IDLE.
    - Accept two-op instruction: load phase-0 micro-op, go EXPAND, latch operands.
    - Accept HALT: load HALT micro-op, go HALTED.
  - EXPAND:
    - in_ready=0.
    - When phase 0 is accepted (out_ready && out_valid): load phase-1 micro-op (out_phase=1, same targets), go IDLE.
  - HALTED:
    - in_ready=0; halted=1.
    - The HALT micro-op still drains normally.
    - resume=1 moves to IDLE on the next edge; resume outside HALTED is ignored.
- Illegal opcode (default build):
  - Emitted as NOP ctrl with out_illegal=1, single micro-op, no state change.
- Simultaneous accept-in and accept-out in the same cycle is legal: output reloads, no bubble.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - An illegal opcode emits a micro-op with out_illegal=1 and ctrl TRAP bit set, then enters HALTED.
  - A sticky err_illegal output (1 bit) is cleared only by rst, not by resume.
- When undefined: default behaviour above; no err_illegal port.

Decomposition:
- Package decode_pkg holds:
  - Opcode localparams.
  - Control-bit index constants (ALU_OP, REG_WE, MEM_RD, MEM_WR, PC_LD, OUT_LD, HALT, TRAP, ...).
  - The state enum typedef.
  - Function ctrl_rom(opcode, operand, phase) returning CTRL_W bits.
- One natural sub-module: decode_rom, a pure combinational wrapper of ctrl_rom plus the one-hot target decode.
- The FSM and output register stay in decode_stage.

Test Plan:
- rst=1 during EXPAND after 0100_0110 accepted -> next cycle out_valid=0, in_ready=1, phase-1 micro-op never appears.
- Stream 1100_0101, 1101_1010, 1110_1111 with out_ready=1 -> three back-to-back micro-ops:
  - tgt1/tgt2 = 0010/0010, 0100/0100, 1000/1000.
  - in_ready stays 1.
- 0100_0110 then out_ready low 3 cycles -> phase-0 micro-op held stable, then:
  - phase-1 micro-op with MEM_RD set and tgt1=0010.
  - in_ready=0 until phase 1 is loaded.
- 0000_0001 -> HALT micro-op, halted=1, in_ready=0 for 5 cycles; resume pulse -> in_ready=1 next cycle; 0000_0010 then accepted.
- 1011_0000 and 1111_1111 -> NOP ctrl, out_illegal=1, no halt.
  - With DECODE_ILLEGAL_TRAP_EN: TRAP set, halted=1, err_illegal=1 persists through resume.
- Random valid/ready toggling over the full 256-opcode sweep -> scoreboard matches ctrl_rom reference, no drop or duplicate.
